// File: rtl/camera_pkg.sv
// camera_pkg: shared types and constants for the DVP capture front end.
package camera_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DROP     = 2'd3
    } cap_state_e;

    localparam int BUF_IDX_W   = 3;
    localparam int DEF_H_BYTES = 2560;
    localparam int DEF_V_LINES = 720;

    // Camera bytes per packed DDR word
    function automatic int bpw(input int data_w, input int pix_w);
        return data_w / pix_w;
    endfunction

endpackage

// File: rtl/camera_byte_packer.sv
// camera_byte_packer: shifts camera bytes into DDR words (first byte in MSBs),
// flushes a partial word zero-padded in the LSBs, and registers the word strobe.
module camera_byte_packer
    import camera_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              byte_vld_i,
    input  logic              flush_i,
    input  logic [PIX_W-1:0]  byte_i,
    output logic              wr_en_o,
    output logic [DATA_W-1:0] wr_data_o
);

    localparam int BPW   = bpw(DATA_W, PIX_W);
    localparam int CNT_W = $clog2(BPW + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              en_q, en_d;

    // Accumulate bytes; emit a word on the last byte or on a flush of a partial word
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        data_d = data_q;
        en_d   = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (byte_vld_i) begin
            acc_d = {acc_q[DATA_W-PIX_W-1:0], byte_i};
            if (cnt_q == CNT_W'(BPW - 1)) begin
                en_d   = 1'b1;
                data_d = acc_d;
                cnt_d  = '0;
                acc_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (flush_i && (cnt_q != '0)) begin
            en_d   = 1'b1;
            data_d = acc_q << (PIX_W * (BPW - int'(cnt_q)));
            cnt_d  = '0;
            acc_d  = '0;
        end
    end

    // Packer state and registered word output
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            data_q <= '0;
            en_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            data_q <= data_d;
            en_q   <= en_d;
        end
    end

    assign wr_en_o   = en_q;
    assign wr_data_o = data_q;

endmodule

// File: rtl/camera_frame_packer.sv
// camera_frame_packer: DVP capture front end with frame-buffer rotation.
// Optional build macro CAPTURE_GEOM_CHECK_EN adds geom_err line/frame geometry checking.
//
// state       | meaning
// ST_IDLE     | sensor not configured, nothing captured
// ST_WAIT_SOF | waiting for vsync falling edge
// ST_ACTIVE   | capturing into wr_buf
// ST_DROP     | no free buffer, frame discarded
module camera_frame_packer
    import camera_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int DATA_W  = 64,
    parameter int H_BYTES = DEF_H_BYTES,
    parameter int V_LINES = DEF_V_LINES,
    parameter int NUM_BUF = 3,
    parameter int ADDR_W  = 18
) (
    input  logic                 camera_pclk,
    input  logic                 rst_n,
    input  logic                 reg_conf_done,
    input  logic                 camera_vsync,
    input  logic                 camera_href,
    input  logic [PIX_W-1:0]     camera_data,
    input  logic                 rd_done,
    input  logic [BUF_IDX_W-1:0] rd_buf,
    output logic                 wr_en,
    output logic [DATA_W-1:0]    wr_data,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [BUF_IDX_W-1:0] wr_buf,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic [BUF_IDX_W-1:0] done_buf,
    output logic [11:0]          h_count,
    output logic [10:0]          v_count,
    output logic [7:0]           drop_cnt
`ifdef CAPTURE_GEOM_CHECK_EN
    ,
    output logic [1:0]           geom_err
`endif
);

    cap_state_e           state_q, state_d;
    logic                 vs_s1_q, vs_s2_q, vs_s3_q, href_q;
    logic [NUM_BUF-1:0]   busy_q, busy_d, busy_rel;
    logic [BUF_IDX_W-1:0] wr_buf_q, wr_buf_d, done_buf_q, done_buf_d, sel_idx;
    logic                 done_valid_q, done_valid_d, sel_found, rd_ok;
    logic                 fs_q, fs_d, fd_q, fd_d;
    logic [7:0]           drop_q, drop_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [11:0]          h_q, h_d;
    logic [10:0]          v_q, v_d;
    logic                 sof, eof, href_fall, active, frame_bad;

    assign sof       = vs_s3_q & ~vs_s2_q;
    assign eof       = ~vs_s3_q & vs_s2_q;
    assign href_fall = href_q & ~camera_href;
    assign active    = (state_q == ST_ACTIVE);

    camera_byte_packer #(.PIX_W(PIX_W), .DATA_W(DATA_W)) u_packer (
        .clk_i      (camera_pclk),
        .rst_n_i    (rst_n),
        .clear_i    (~reg_conf_done | ~active),
        .byte_vld_i (active & camera_href),
        .flush_i    (active & (href_fall | eof)),
        .byte_i     (camera_data),
        .wr_en_o    (wr_en),
        .wr_data_o  (wr_data)
    );

    // Apply reader release, then pick the lowest free buffer other than the last completed one
    always_comb begin
        rd_ok = rd_done && (int'(rd_buf) < NUM_BUF) && !(active && (rd_buf == wr_buf_q));
        busy_rel = busy_q;
        for (int i = 0; i < NUM_BUF; i++)
            if (rd_ok && (rd_buf == BUF_IDX_W'(i))) busy_rel[i] = 1'b0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--)
            if (!busy_rel[i] && !(done_valid_q && (done_buf_q == BUF_IDX_W'(i)))) begin
                sel_found = 1'b1;
                sel_idx   = BUF_IDX_W'(i);
            end
    end

    // Capture FSM next state, buffer bookkeeping and frame pulses
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_rel;
        wr_buf_d     = wr_buf_q;
        done_buf_d   = done_buf_q;
        done_valid_d = done_valid_q;
        drop_d       = drop_q;
        fs_d         = 1'b0;
        fd_d         = 1'b0;
        if (!reg_conf_done) begin
            state_d = ST_IDLE;
            // An abandoned frame's buffer goes back to the pool so it cannot leak
            if (active)
                for (int i = 0; i < NUM_BUF; i++)
                    if (wr_buf_q == BUF_IDX_W'(i)) busy_d[i] = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_SOF;
                ST_WAIT_SOF: begin
                    if (sof) begin
                        fs_d = 1'b1;
                        if (sel_found) begin
                            state_d  = ST_ACTIVE;
                            wr_buf_d = sel_idx;
                            for (int i = 0; i < NUM_BUF; i++)
                                if (sel_idx == BUF_IDX_W'(i)) busy_d[i] = 1'b1;
                        end else begin
                            state_d = ST_DROP;
                            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (eof) begin
                        state_d = ST_WAIT_SOF;
                        if (frame_bad) begin
                            for (int i = 0; i < NUM_BUF; i++)
                                if (wr_buf_q == BUF_IDX_W'(i)) busy_d[i] = 1'b0;
                        end else begin
                            fd_d         = 1'b1;
                            done_buf_d   = wr_buf_q;
                            done_valid_d = 1'b1;
                        end
                    end
                end
                ST_DROP: if (eof) state_d = ST_WAIT_SOF;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Word address, line byte count and line count
    always_comb begin
        addr_d = addr_q;
        if (reg_conf_done && (state_q == ST_WAIT_SOF) && sof) addr_d = '0;
        else if (wr_en) addr_d = addr_q + ADDR_W'(1);
        h_d = camera_href ? h_q + 12'd1 : 12'd0;
        v_d = v_q;
        if (sof) v_d = '0;
        else if (href_fall && (v_q != 11'h7FF)) v_d = v_q + 11'd1;
    end

    // State, sync chain and counter registers
    always_ff @(posedge camera_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vs_s1_q      <= 1'b0;
            vs_s2_q      <= 1'b0;
            vs_s3_q      <= 1'b0;
            href_q       <= 1'b0;
            busy_q       <= '0;
            wr_buf_q     <= '0;
            done_buf_q   <= '0;
            done_valid_q <= 1'b0;
            drop_q       <= '0;
            fs_q         <= 1'b0;
            fd_q         <= 1'b0;
            addr_q       <= '0;
            h_q          <= '0;
            v_q          <= '0;
        end else begin
            state_q      <= state_d;
            vs_s1_q      <= camera_vsync;
            vs_s2_q      <= vs_s1_q;
            vs_s3_q      <= vs_s2_q;
            href_q       <= camera_href;
            busy_q       <= busy_d;
            wr_buf_q     <= wr_buf_d;
            done_buf_q   <= done_buf_d;
            done_valid_q <= done_valid_d;
            drop_q       <= drop_d;
            fs_q         <= fs_d;
            fd_q         <= fd_d;
            addr_q       <= addr_d;
            h_q          <= h_d;
            v_q          <= v_d;
        end
    end

`ifdef CAPTURE_GEOM_CHECK_EN
    logic [1:0] geom_q, geom_d;
    assign frame_bad = (v_q != 11'(V_LINES));

    // Sticky geometry flags, cleared at each start of frame
    always_comb begin
        geom_d = geom_q;
        if (sof) geom_d = '0;
        else begin
            if (active && href_fall && (h_q != 12'(H_BYTES))) geom_d[0] = 1'b1;
            if (active && eof && reg_conf_done && frame_bad) geom_d[1] = 1'b1;
        end
    end

    // Geometry flag register
    always_ff @(posedge camera_pclk or negedge rst_n) begin
        if (!rst_n) geom_q <= '0;
        else        geom_q <= geom_d;
    end

    assign geom_err = geom_q;
`else
    logic [31:0] unused_geom;
    assign unused_geom = H_BYTES ^ V_LINES;
    assign frame_bad   = 1'b0;
`endif

    assign wr_addr     = addr_q;
    assign wr_buf      = wr_buf_q;
    assign frame_start = fs_q;
    assign frame_done  = fd_q;
    assign done_buf    = done_buf_q;
    assign h_count     = h_q;
    assign v_count     = v_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_camera_frame_packer.sv
// tb_camera_frame_packer: scoreboard bench for camera_frame_packer.
module tb_camera_frame_packer;

    logic        camera_pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_conf_done = 1'b0;
    logic        camera_vsync = 1'b1;
    logic        camera_href = 1'b0;
    logic [7:0]  camera_data = 8'h00;
    logic        rd_done = 1'b0;
    logic [2:0]  rd_buf = 3'd0;
    logic        wr_en;
    logic [63:0] wr_data;
    logic [17:0] wr_addr;
    logic [2:0]  wr_buf;
    logic        frame_start;
    logic        frame_done;
    logic [2:0]  done_buf;
    logic [11:0] h_count;
    logic [10:0] v_count;
    logic [7:0]  drop_cnt;
`ifdef CAPTURE_GEOM_CHECK_EN
    logic [1:0]  geom_err;
`endif

    camera_frame_packer #(
        .PIX_W(8), .DATA_W(64), .H_BYTES(16), .V_LINES(2), .NUM_BUF(3), .ADDR_W(18)
    ) dut (
        .camera_pclk   (camera_pclk),
        .rst_n         (rst_n),
        .reg_conf_done (reg_conf_done),
        .camera_vsync  (camera_vsync),
        .camera_href   (camera_href),
        .camera_data   (camera_data),
        .rd_done       (rd_done),
        .rd_buf        (rd_buf),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_addr       (wr_addr),
        .wr_buf        (wr_buf),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .done_buf      (done_buf),
        .h_count       (h_count),
        .v_count       (v_count),
        .drop_cnt      (drop_cnt)
`ifdef CAPTURE_GEOM_CHECK_EN
        ,
        .geom_err      (geom_err)
`endif
    );

    always #5 camera_pclk = ~camera_pclk;

    typedef struct packed {
        logic [2:0]  b;
        logic [17:0] a;
        logic [63:0] d;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_seen = 0;
    int          fs_seen = 0;
    int          fd_seen = 0;
    logic [2:0]  fd_buf = 3'd0;
    logic [2:0]  exp_buf = 3'd0;
    logic [17:0] exp_addr = 18'd0;

    // Expected word: byte j of the word lands in bits [63-8j -: 8], remainder zero
    function automatic logic [63:0] pack_word(input int base, input int nbytes);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < nbytes; j++) w[63-8*j -: 8] = 8'(base + j);
        return w;
    endfunction

    // Output monitor: scoreboard pop on every word, pulse bookkeeping
    always @(negedge camera_pclk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (frame_start) fs_seen++;
            if (frame_done) begin
                fd_seen++;
                fd_buf = done_buf;
            end
            if (wr_en) begin
                wr_seen++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got buf=%0d addr=%0d data=%h, required no write",
                             wr_buf, wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_buf !== e.b || wr_addr !== e.a || wr_data !== e.d) begin
                        n_fail++;
                        $display("FAIL wr_word: got buf=%0d addr=%0d data=%h, required buf=%0d addr=%0d data=%h",
                                 wr_buf, wr_addr, wr_data, e.b, e.a, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge camera_pclk);
        rst_n = 1'b0; reg_conf_done = 1'b0; camera_vsync = 1'b1;
        camera_href = 1'b0; camera_data = 8'h00; rd_done = 1'b0; rd_buf = 3'd0;
        repeat (3) @(negedge camera_pclk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic enable_conf();
        @(negedge camera_pclk);
        reg_conf_done = 1'b1;
        repeat (3) @(negedge camera_pclk);
    endtask

    // vsync falls; optional rd_done lands on the cycle the synchronised SOF is seen
    task automatic start_frame(input bit rd, input logic [2:0] rb);
        @(negedge camera_pclk);
        camera_vsync = 1'b0;
        @(posedge camera_pclk);
        @(posedge camera_pclk);
        @(negedge camera_pclk);
        rd_done = rd; rd_buf = rb;
        @(negedge camera_pclk);
        rd_done = 1'b0;
        repeat (3) @(negedge camera_pclk);
    endtask

    task automatic end_frame();
        @(negedge camera_pclk);
        camera_vsync = 1'b1;
        repeat (6) @(negedge camera_pclk);
    endtask

    task automatic send_line(input int n, input int base, input bit push, output int h_end);
        exp_t e;
        int   nb;
        if (push) begin
            for (int w = 0; w * 8 < n; w++) begin
                nb = (n - 8 * w >= 8) ? 8 : n - 8 * w;
                e.b = exp_buf; e.a = exp_addr; e.d = pack_word(base + 8 * w, nb);
                exp_q.push_back(e);
                exp_addr++;
            end
        end
        for (int i = 0; i < n; i++) begin
            @(negedge camera_pclk);
            camera_href = 1'b1; camera_data = 8'(base + i);
        end
        @(negedge camera_pclk);
        camera_href = 1'b0; camera_data = 8'h00;
        h_end = int'(h_count);
        repeat (3) @(negedge camera_pclk);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            @(negedge camera_pclk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge camera_pclk);
        rst_n = 1'b0; camera_href = 1'b1; camera_data = 8'hA5; reg_conf_done = 1'b1;
        camera_vsync = 1'b0; rd_done = 1'b1; rd_buf = 3'd1;
        repeat (4) @(negedge camera_pclk);
        n_checks++;
        if (wr_en !== 1'b0 || wr_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_wr: got wr_en=%b data=%h, required 0", wr_en, wr_data);
        end
        n_checks++;
        if (wr_addr !== 18'd0 || wr_buf !== 3'd0 || done_buf !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idx: got addr=%0d buf=%0d done_buf=%0d, required 0", wr_addr, wr_buf, done_buf);
        end
        n_checks++;
        if (frame_start !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulse: got fs=%b fd=%b, required 0", frame_start, frame_done);
        end
        n_checks++;
        if (h_count !== 12'd0 || v_count !== 11'd0 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got h=%0d v=%0d drop=%0d, required 0", h_count, v_count, drop_cnt);
        end
        do_reset();
    endtask

    task automatic test_pack();
        int h, fs0, fd0;
        do_reset();
        enable_conf();
        exp_buf = 3'd0; exp_addr = 18'd0; fs0 = fs_seen; fd0 = fd_seen;
        start_frame(1'b0, 3'd0);
        send_line(16, 0, 1'b1, h);
        n_checks++;
        if (h !== 16) begin
            n_fail++;
            $display("FAIL h_count_end: got %0d, required 16", h);
        end
        n_checks++;
        if (h_count !== 12'd0) begin
            n_fail++;
            $display("FAIL h_count_idle: got %0d, required 0", h_count);
        end
        send_line(16, 0, 1'b1, h);
        n_checks++;
        if (v_count !== 11'd2) begin
            n_fail++;
            $display("FAIL v_count: got %0d, required 2", v_count);
        end
        end_frame();
        wait_drain();
        n_checks++;
        if (fs_seen - fs0 !== 1 || fd_seen - fd0 !== 1) begin
            n_fail++;
            $display("FAIL frame_pulses: got fs=%0d fd=%0d, required 1 and 1", fs_seen - fs0, fd_seen - fd0);
        end
        n_checks++;
        if (fd_buf !== 3'd0 || wr_addr !== 18'd4) begin
            n_fail++;
            $display("FAIL pack_end: got done_buf=%0d addr=%0d, required 0 and 4", fd_buf, wr_addr);
        end
    endtask

    task automatic test_partial();
        int h, w0;
        do_reset();
        enable_conf();
        exp_buf = 3'd0; exp_addr = 18'd0;
        start_frame(1'b0, 3'd0);
        w0 = wr_seen;
        send_line(13, 8'h20, 1'b1, h);
        wait_drain();
        n_checks++;
        if (wr_seen - w0 !== 2) begin
            n_fail++;
            $display("FAIL partial_count: got %0d writes, required 2", wr_seen - w0);
        end
        n_checks++;
        if (v_count !== 11'd1) begin
            n_fail++;
            $display("FAIL partial_v: got %0d, required 1", v_count);
        end
        end_frame();
    endtask

    task automatic test_buffers();
        int h, fd0;
        do_reset();
        enable_conf();
        for (int f = 0; f < 3; f++) begin
            exp_buf = 3'(f); exp_addr = 18'd0;
            start_frame(1'b0, 3'd0);
            send_line(16, 16 * f, 1'b1, h);
            send_line(16, 16 * f + 8, 1'b1, h);
            end_frame();
            wait_drain();
            n_checks++;
            if (fd_buf !== 3'(f) || done_buf !== 3'(f)) begin
                n_fail++;
                $display("FAIL rot_done_buf: got fd_buf=%0d done_buf=%0d, required %0d", fd_buf, done_buf, f);
            end
        end
        fd0 = fd_seen;
        start_frame(1'b0, 3'd0);
        send_line(16, 8'h70, 1'b0, h);
        end_frame();
        n_checks++;
        if (drop_cnt !== 8'd1 || fd_seen !== fd0) begin
            n_fail++;
            $display("FAIL drop_first: got drop=%0d fd=%0d, required 1 and 0", drop_cnt, fd_seen - fd0);
        end
        start_frame(1'b1, 3'd7);
        send_line(16, 8'h80, 1'b0, h);
        end_frame();
        n_checks++;
        if (drop_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL drop_bad_rd: got drop=%0d, required 2", drop_cnt);
        end
        exp_buf = 3'd0; exp_addr = 18'd0;
        start_frame(1'b1, 3'd0);
        n_checks++;
        if (wr_buf !== 3'd0) begin
            n_fail++;
            $display("FAIL rd_on_sof_buf: got %0d, required 0", wr_buf);
        end
        send_line(16, 8'h90, 1'b1, h);
        send_line(16, 8'hA0, 1'b1, h);
        end_frame();
        wait_drain();
        n_checks++;
        if (drop_cnt !== 8'd2 || fd_buf !== 3'd0) begin
            n_fail++;
            $display("FAIL rd_on_sof_end: got drop=%0d done_buf=%0d, required 2 and 0", drop_cnt, fd_buf);
        end
    endtask

    task automatic test_conf_drop();
        int h, w0;
        exp_t e;
        do_reset();
        enable_conf();
        exp_buf = 3'd0; exp_addr = 18'd0;
        start_frame(1'b0, 3'd0);
        e.b = 3'd0; e.a = 18'd0; e.d = pack_word(8'h40, 8);
        exp_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            @(negedge camera_pclk);
            camera_href = 1'b1; camera_data = 8'(8'h40 + i);
        end
        @(negedge camera_pclk);
        reg_conf_done = 1'b0; camera_data = 8'h4A;
        @(negedge camera_pclk);
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL conf_drop_wr: got wr_en=%b, required 0", wr_en);
        end
        camera_href = 1'b0; camera_data = 8'h00;
        w0 = wr_seen;
        repeat (5) @(negedge camera_pclk);
        n_checks++;
        if (wr_seen !== w0) begin
            n_fail++;
            $display("FAIL conf_drop_flush: got %0d writes, required 0", wr_seen - w0);
        end
        wait_drain();
        enable_conf();
        end_frame();
        exp_buf = 3'd0; exp_addr = 18'd0;
        start_frame(1'b0, 3'd0);
        send_line(8, 8'h50, 1'b1, h);
        end_frame();
        wait_drain();
    endtask

`ifdef CAPTURE_GEOM_CHECK_EN
    task automatic test_geom();
        int h, fd0;
        do_reset();
        enable_conf();
        exp_buf = 3'd0; exp_addr = 18'd0; fd0 = fd_seen;
        start_frame(1'b0, 3'd0);
        send_line(12, 8'h60, 1'b1, h);
        n_checks++;
        if (geom_err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL geom_line: got %b, required 1", geom_err[0]);
        end
        end_frame();
        wait_drain();
        n_checks++;
        if (fd_seen !== fd0 || geom_err !== 2'b11) begin
            n_fail++;
            $display("FAIL geom_frame: got fd=%0d err=%b, required 0 and 11", fd_seen - fd0, geom_err);
        end
        exp_buf = 3'd0; exp_addr = 18'd0;
        start_frame(1'b0, 3'd0);
        n_checks++;
        if (geom_err !== 2'b00) begin
            n_fail++;
            $display("FAIL geom_clear: got %b, required 00", geom_err);
        end
        send_line(16, 8'h00, 1'b1, h);
        send_line(16, 8'h10, 1'b1, h);
        end_frame();
        wait_drain();
        n_checks++;
        if (fd_seen !== fd0 + 1 || fd_buf !== 3'd0) begin
            n_fail++;
            $display("FAIL geom_good: got fd=%0d done_buf=%0d, required 1 and 0", fd_seen - fd0, fd_buf);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pack();
        test_partial();
        test_buffers();
        test_conf_drop();
`ifdef CAPTURE_GEOM_CHECK_EN
        test_geom();
`endif
        repeat (5) @(negedge camera_pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
